// File: rtl/sop_sweep_pkg.sv
// Shared types and constants for the sum-of-products sweep controller.
// Mask layout: out0 in [15:0], out1 in [31:16], out2 in [47:32]; bit i of each slice is row i.
package sop_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_ROWS    = 16;
    localparam int N_OUT     = 3;
    localparam int ROW_W     = 4;
    localparam int ERR_W     = 5;
    localparam int MASK_W    = N_ROWS * N_OUT;

    localparam int MASK0_LSB = 0;
    localparam int MASK1_LSB = N_ROWS;
    localparam int MASK2_LSB = 2 * N_ROWS;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

    // Gathers the expected {out2,out1,out0} for one row out of the packed masks.
    function automatic logic [N_OUT-1:0] maskBits(input logic [MASK_W-1:0] mask,
                                                  input logic [ROW_W-1:0]  row);
        logic [N_OUT-1:0] bits;
        bits[0] = mask[MASK0_LSB + int'(row)];
        bits[1] = mask[MASK1_LSB + int'(row)];
        bits[2] = mask[MASK2_LSB + int'(row)];
        return bits;
    endfunction

endpackage

// File: rtl/sop_sweep_ctrl_row_check.sv
// Combinational per-row comparison: expected output vector for the current row
// and the per-output mismatch mask against the sampled datapath outputs.
module sop_row_check
    import sop_sweep_pkg::*;
(
    input  logic [ROW_W-1:0]  i_row,
    input  logic [MASK_W-1:0] i_mask,
    input  logic [N_OUT-1:0]  i_sop_in,
    output logic [N_OUT-1:0]  o_exp_vec,
    output logic [N_OUT-1:0]  o_mism
);

    always_comb begin
        o_exp_vec = maskBits(i_mask, i_row);
        o_mism    = i_sop_in ^ o_exp_vec;
    end

endmodule

// File: rtl/sop_sweep_ctrl.sv
// Self-check sequencer: walks a 4-input SoP datapath through all 16 rows and checks its outputs.
// Optional observed-truth-table capture is enabled by defining SOP_SWEEP_OBS_EN.
module sop_sweep_ctrl
    import sop_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [47:0] i_exp_mask,
    input  logic [2:0]  i_sop_in,
    output logic        o_x,
    output logic        o_y,
    output logic        o_w,
    output logic        o_z,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [4:0]  o_err_count,
    output logic        o_first_err_valid,
    output logic [3:0]  o_first_err_idx,
    output logic [2:0]  o_first_err_out,
    output logic [47:0] o_obs_table
);

    localparam logic [ROW_W-1:0] SETTLE_LD = ROW_W'(SETTLE);

    state_t             r_state;
    state_t             w_stateNext;
    logic [ROW_W-1:0]   r_row;
    logic [ROW_W-1:0]   r_settleCnt;
    logic [MASK_W-1:0]  r_mask;
    logic [ERR_W-1:0]   r_errCount;
    logic               r_firstErrValid;
    logic [ROW_W-1:0]   r_firstErrIdx;
    logic [N_OUT-1:0]   r_firstErrOut;
    logic               r_pass;

    logic               w_accept;
    logic               w_sample;
    logic               w_settleDec;
    logic               w_lastRow;
    logic               w_rowFail;
    logic [N_OUT-1:0]   w_expVec;
    logic [N_OUT-1:0]   w_mism;
    logic [ERR_W-1:0]   w_errCountNext;

    sop_row_check u_row_check (
        .i_row     (r_row),
        .i_mask    (r_mask),
        .i_sop_in  (i_sop_in),
        .o_exp_vec (w_expVec),
        .o_mism    (w_mism)
    );

    assign w_lastRow      = (r_row == LAST_ROW);
    assign w_rowFail      = (i_sop_in != w_expVec);
    assign w_errCountNext = r_errCount + {{(ERR_W-1){1'b0}}, w_rowFail};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Abort outranks sampling, so an aborted row is never scored.
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        w_settleDec = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                if (i_abort) begin
                    w_stateNext = IDLE;
                end else if (r_settleCnt != '0) begin
                    w_settleDec = 1'b1;
                end else begin
                    w_sample = 1'b1;
                    if (w_lastRow) begin
                        w_stateNext = DONE;
                    end
                end
            end
            DONE: begin
                o_done      = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_row           <= '0;
            r_settleCnt     <= '0;
            r_mask          <= '0;
            r_errCount      <= '0;
            r_firstErrValid <= 1'b0;
            r_firstErrIdx   <= '0;
            r_firstErrOut   <= '0;
            r_pass          <= 1'b0;
        end else if (w_accept) begin
            r_row           <= '0;
            r_settleCnt     <= SETTLE_LD;
            r_mask          <= i_exp_mask;
            r_errCount      <= '0;
            r_firstErrValid <= 1'b0;
            r_firstErrIdx   <= '0;
            r_firstErrOut   <= '0;
            r_pass          <= 1'b0;
        end else if (w_settleDec) begin
            r_settleCnt <= r_settleCnt - ROW_W'(1);
        end else if (w_sample) begin
            r_errCount <= w_errCountNext;
            if (w_rowFail && !r_firstErrValid) begin
                r_firstErrValid <= 1'b1;
                r_firstErrIdx   <= r_row;
                r_firstErrOut   <= w_mism;
            end
            // The last row stays on the vector pins after the sweep ends.
            if (w_lastRow) begin
                r_pass <= (w_errCountNext == '0);
            end else begin
                r_row       <= r_row + ROW_W'(1);
                r_settleCnt <= SETTLE_LD;
            end
        end
    end

`ifdef SOP_SWEEP_OBS_EN
    logic [MASK_W-1:0] r_obsTable;

    always_ff @(posedge i_clk) begin
        if (i_reset || w_accept) begin
            r_obsTable <= '0;
        end else if (w_sample) begin
            for (int k = 0; k < N_OUT; k++) begin
                r_obsTable[k*N_ROWS + int'(r_row)] <= i_sop_in[k];
            end
        end
    end

    assign o_obs_table = r_obsTable;
`else
    assign o_obs_table = '0;
`endif

    assign {o_x, o_y, o_w, o_z} = r_row;
    assign o_pass               = r_pass;
    assign o_err_count          = r_errCount;
    assign o_first_err_valid    = r_firstErrValid;
    assign o_first_err_idx      = r_firstErrIdx;
    assign o_first_err_out      = r_firstErrOut;

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Bench for sop_sweep_ctrl: two instances (SETTLE=1 and SETTLE=0) driven by a table-based
// datapath model with injectable per-row faults, checked against a row-by-row reference.
module tb_sop_sweep_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetA, resetB, startA, startB, abortA, abortB;
    logic [47:0] expMask;
    logic [2:0]  sopA, sopB;

    logic        xA, yA, wA, zA, busyA, doneA, passA, fvA;
    logic [4:0]  errA;
    logic [3:0]  fiA;
    logic [2:0]  foA;
    logic [47:0] obsA;
    logic        xB, yB, wB, zB, busyB, doneB, passB, fvB;
    logic [4:0]  errB;
    logic [3:0]  fiB;
    logic [2:0]  foB;
    logic [47:0] obsB;

    logic [15:0] gold [3];
    logic [2:0]  faultXor [16];
    int          checks = 0;
    int          errors = 0;
    int          curSel = 0;

    logic [3:0]  rowA, rowB;
    assign rowA = {xA, yA, wA, zA};
    assign rowB = {xB, yB, wB, zB};

    // Datapath model: the ideal truth table with an optional per-row output flip.
    assign sopA = {gold[2][rowA], gold[1][rowA], gold[0][rowA]} ^ faultXor[rowA];
    assign sopB = {gold[2][rowB], gold[1][rowB], gold[0][rowB]} ^ faultXor[rowB];

    logic [3:0]  oRow;
    logic        oBusy, oDone, oPass, oFv;
    logic [4:0]  oErr;
    logic [3:0]  oFi;
    logic [2:0]  oFo;
    logic [47:0] oObs;
    assign oRow  = (curSel == 0) ? rowA  : rowB;
    assign oBusy = (curSel == 0) ? busyA : busyB;
    assign oDone = (curSel == 0) ? doneA : doneB;
    assign oPass = (curSel == 0) ? passA : passB;
    assign oFv   = (curSel == 0) ? fvA   : fvB;
    assign oErr  = (curSel == 0) ? errA  : errB;
    assign oFi   = (curSel == 0) ? fiA   : fiB;
    assign oFo   = (curSel == 0) ? foA   : foB;
    assign oObs  = (curSel == 0) ? obsA  : obsB;

    sop_sweep_ctrl #(.SETTLE(1)) dutA (
        .i_clk(clk), .i_reset(resetA), .i_start(startA), .i_abort(abortA),
        .i_exp_mask(expMask), .i_sop_in(sopA),
        .o_x(xA), .o_y(yA), .o_w(wA), .o_z(zA),
        .o_busy(busyA), .o_done(doneA), .o_pass(passA), .o_err_count(errA),
        .o_first_err_valid(fvA), .o_first_err_idx(fiA), .o_first_err_out(foA),
        .o_obs_table(obsA)
    );

    sop_sweep_ctrl #(.SETTLE(0)) dutB (
        .i_clk(clk), .i_reset(resetB), .i_start(startB), .i_abort(abortB),
        .i_exp_mask(expMask), .i_sop_in(sopB),
        .o_x(xB), .o_y(yB), .o_w(wB), .o_z(zB),
        .o_busy(busyB), .o_done(doneB), .o_pass(passB), .o_err_count(errB),
        .o_first_err_valid(fvB), .o_first_err_idx(fiB), .o_first_err_out(foB),
        .o_obs_table(obsB)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [47:0] goldVec();
        return {gold[2], gold[1], gold[0]};
    endfunction

    task automatic clearFaults();
        for (int r = 0; r < 16; r++) faultXor[r] = 3'b000;
    endtask

    task automatic stuckOut0();
        for (int r = 0; r < 16; r++) faultXor[r] = {2'b00, gold[0][r]};
    endtask

    task automatic setStart(input int sel, input logic v, input logic withAbort);
        if (sel == 0) begin
            startA = v;
            abortA = v & withAbort;
        end else begin
            startB = v;
        end
    endtask

    // Reference results after the first rowsDone rows have been scored.
    task automatic checkResults(input string tag, input int rowsDone, input bit finished);
        int          cnt;
        int          first;
        logic [2:0]  fo;
        logic [47:0] obs;
        cnt = 0; first = -1; fo = 3'b000; obs = '0;
        for (int r = 0; r < rowsDone; r++) begin
            if (faultXor[r] != 3'b000) begin
                cnt++;
                if (first < 0) begin
                    first = r;
                    fo    = faultXor[r];
                end
            end
            for (int k = 0; k < 3; k++) obs[k*16 + r] = gold[k][r] ^ faultXor[r][k];
        end
        checkOutput({tag, "_errs"},  oErr, cnt);
        checkOutput({tag, "_fv"},    oFv,  (first >= 0) ? 1 : 0);
        checkOutput({tag, "_fidx"},  oFi,  (first >= 0) ? first : 0);
        checkOutput({tag, "_fout"},  oFo,  fo);
        checkOutput({tag, "_pass"},  oPass, (finished && cnt == 0) ? 1 : 0);
`ifdef SOP_SWEEP_OBS_EN
        checkOutput({tag, "_obs"},   oObs, obs);
`else
        checkOutput({tag, "_obs"},   oObs, 48'h0);
`endif
    endtask

    // Full sweep: start pulse, per-cycle row schedule, done timing, results, pulse width.
    task automatic applyStimulus(input int sel, input int settle, input int injectAt,
                                 input logic abortWithStart, input string tag);
        int n;
        int lim;
        lim    = 16 * (settle + 1) + 1;
        curSel = sel;
        expMask = goldVec();
        @(negedge clk);
        setStart(sel, 1'b1, abortWithStart);
        @(negedge clk);
        setStart(sel, 1'b0, 1'b0);
        n = 1;
        checkOutput({tag, "_busy_rise"}, oBusy, 1);
        while (oDone !== 1'b1 && n < lim + 20) begin
            if (n < lim) checkOutput({tag, "_row"}, oRow, (n - 1) / (settle + 1));
            if (n == injectAt) begin
                setStart(sel, 1'b1, 1'b0);
                expMask = ~goldVec();
            end else begin
                setStart(sel, 1'b0, 1'b0);
            end
            @(negedge clk);
            n++;
        end
        setStart(sel, 1'b0, 1'b0);
        checkOutput({tag, "_done_cycle"}, n, lim);
        checkOutput({tag, "_busy_at_done"}, oBusy, 0);
        checkResults(tag, 16, 1'b1);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, oDone, 0);
        checkOutput({tag, "_row_hold"}, oRow, 4'hF);
        expMask = goldVec();
    endtask

    task automatic waitRow(input logic [3:0] target, input string tag);
        int n;
        n = 0;
        while (oRow !== target && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_reach_row"}, (n < 200) ? 1 : 0, 1);
    endtask

    task automatic expectNoDone(input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (oDone === 1'b1) seen++;
        end
        checkOutput({tag, "_no_done"}, seen, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetA = 1'b1; resetB = 1'b1;
        startA = 1'b0; startB = 1'b0;
        abortA = 1'b0; abortB = 1'b0;
        gold[0] = 16'h5266; gold[1] = 16'h16C5; gold[2] = 16'h20AE;
        clearFaults();
        expMask = goldVec();
        repeat (3) @(negedge clk);
        resetA = 1'b0; resetB = 1'b0;

        curSel = 0;
        checkOutput("rst_row",  oRow, 0);
        checkOutput("rst_busy", oBusy, 0);
        checkOutput("rst_done", oDone, 0);
        checkResults("rst", 0, 1'b0);

        applyStimulus(0, 1, -1, 1'b0, "t1_clean");

        faultXor[9] = 3'b010;
        applyStimulus(0, 1, -1, 1'b0, "t2_flip");

        clearFaults();
        stuckOut0();
        applyStimulus(0, 1, -1, 1'b0, "t3_stuck");

        // Abort while row 5 is settling: rows 0..4 stay scored.
        curSel = 0;
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        waitRow(4'd5, "t4");
        abortA = 1'b1;
        @(negedge clk);
        abortA = 1'b0;
        checkOutput("t4_abort_busy", oBusy, 0);
        checkOutput("t4_abort_done", oDone, 0);
        checkResults("t4_abort", 5, 1'b0);
        expectNoDone(40, "t4");
        clearFaults();
        applyStimulus(0, 1, -1, 1'b0, "t4_restart");

        // Reset during row 10, then a sweep that sees a stray start while busy.
        stuckOut0();
        curSel = 0;
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        waitRow(4'd10, "t5");
        resetA = 1'b1;
        @(negedge clk);
        resetA = 1'b0;
        checkOutput("t5_rst_row",  oRow, 0);
        checkOutput("t5_rst_busy", oBusy, 0);
        checkOutput("t5_rst_done", oDone, 0);
        checkResults("t5_rst", 0, 1'b0);
        expectNoDone(40, "t5");
        clearFaults();
        applyStimulus(0, 1, 7, 1'b0, "t5_ignored_start");

        applyStimulus(1, 0, -1, 1'b0, "t6_settle0");

        for (int i = 0; i < 8; i++) begin
            gold[0] = 16'($urandom);
            gold[1] = 16'($urandom);
            gold[2] = 16'($urandom);
            for (int r = 0; r < 16; r++)
                faultXor[r] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if (i < 5) applyStimulus(0, 1, -1, 1'(i % 2), "rnd_a");
            else       applyStimulus(1, 0, -1, 1'b0, "rnd_b");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sop_sweep_ctrl.md
Name: sop_sweep_ctrl

Overview:
- Sequencer that drives a 4-input, 3-output sum-of-products datapath through all 16 input combinations.
- Samples the three outputs for each combination and checks each output against a programmable 16-bit minterm mask.
- Reports pass/fail, mismatch count and first failing row.
- Sits between a host/test harness and the SoP block as its self-check controller.

Parameters:
- SETTLE, 1, idle cycles per row between applying a vector and sampling outputs (0..15)
- N_OUT, 3, number of SoP outputs checked (fixed at 3 in this revision)

Ports:
- clk  input  1  clock; single clock domain
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
- abort  input  1  cancels a running sweep; no done pulse
- exp_mask  input  48  expected minterm masks; [15:0]=out0, [31:16]=out1, [47:32]=out2; bit i = expected value for row i
- sop_in  input  3  datapath outputs {out2,out1,out0}
- x, y, w, z  output  1 each  vector bits driven to datapath; {x,y,w,z} = row index, x is MSB
- busy  output  1  high while sweeping
- done  output  1  one-cycle pulse at sweep end
- pass  output  1  1 when err_count==0 after last sweep
- err_count  output  5  rows with at least one mismatching output (0..16)
- first_err_valid  output  1  a mismatch was recorded
- first_err_idx  output  4  row of first mismatch
- first_err_out  output  3  per-output mismatch mask at that row
- obs_table  output  48  observed truth table, same layout as exp_mask

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state IDLE; x,y,w,z=0; busy=0; done=0; pass=0; err_count=0; first_err_valid=0; first_err_idx=0; first_err_out=0; obs_table=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches exp_mask internally, clears err_count, first_err_* and pass.
  - Sets row=0 and settle counter=SETTLE, then enters RUN.
  - busy rises the cycle after start.
- RUN:
  - {x,y,w,z}=row is registered and held stable for SETTLE+1 cycles.
  - While counter>0, decrement the counter.
  - At counter==0, sample sop_in and compute mism = sop_in ^ {mask2[row],mask1[row],mask0[row]}.
  - If mism!=0: increment err_count; if first_err_valid==0, set first_err_valid=1 and record row and mism.
  - Then row++ and reload the counter.
  - Sampling row 15 moves to DONE; no wrap inside a sweep.
- Timing:
  - A sweep occupies exactly 16*(SETTLE+1) cycles in RUN.
  - With the default SETTLE=1, done pulses 33 cycles after the start cycle.
- DONE (one cycle):
  - done=1, busy=0, pass=(err_count==0) using the final-row update.
  - Then returns to IDLE; x,y,w,z keep their last value (1111).
- Result holding: results hold until the next accepted start or reset.
- start while busy: ignored; masks are not re-latched.
- abort in RUN: go to IDLE next cycle with busy=0, done=0, pass=0; partial err_count and first_err_* remain readable.
  - abort has priority over sampling in the same cycle.
  - abort in IDLE or DONE: no effect.
- start and abort together in IDLE: start wins.
- reset mid-sweep: all outputs return to reset values the next cycle; no done pulse.
- exp_mask changes during a sweep have no effect because masks are latched at start.

Optional Feature:
- Macro: SOP_SWEEP_OBS_EN.
- Defined:
  - obs_table[k*16+row] is written with sop_in[k] at each sample.
  - obs_table is cleared on accepted start and on reset.
- Undefined: obs_table is tied to 0 and no capture registers are built. All other behaviour is identical.

Decomposition:
- Package sop_sweep_pkg:
  - state enum (IDLE, RUN, DONE)
  - N_ROWS=16
  - N_OUT=3
  - localparams for mask slice offsets
- Sub-module sop_row_check (combinational):
  - inputs: row, latched masks, sop_in
  - outputs: expected vector and mism mask
- The FSM, counters and result registers stay in sop_sweep_ctrl.

Test Plan:
1. Correct datapath, SETTLE=1:
   - Stimulus: exp_mask={16'h20AE,16'h16C5,16'h5266}; bench model returns the matching outputs; pulse start.
   - Required: done pulses at cycle 33; pass=1; err_count=0; first_err_valid=0. With the macro, obs_table equals exp_mask.
2. Injected fault:
   - Stimulus: same masks; bench flips out1 at row 9.
   - Required: err_count=1; first_err_idx=9; first_err_out=3'b010; pass=0.
3. Multiple faults:
   - Stimulus: out0 stuck 0.
   - Required: err_count=7; first_err_idx=1; first_err_out=3'b001.
4. Abort and restart:
   - Stimulus: abort at row 5 during RUN.
   - Required: busy=0 next cycle; no done. A new start then yields a full sweep with pass=1.
5. Reset mid-sweep and ignored start:
   - Stimulus: reset during row 10.
   - Required: all outputs 0 next cycle. A start pulsed while busy in a later sweep does not change done timing.
6. SETTLE=0:
   - Stimulus: correct datapath, SETTLE=0.
   - Required: done 17 cycles after start; rows advance every cycle; pass=1.
